// File: rtl/ma_clk_ctrl_pkg.sv
// ma_clk_ctrl_pkg: shared FSM encoding and domain indices for the clock control sequencer
package ma_clk_ctrl_pkg;
  localparam int N_DOM_DEF = 5;
  localparam logic [2:0] DOM_CPU = 3'd0;
  localparam logic [2:0] DOM_AXI = 3'd1;
  localparam logic [2:0] DOM_APB = 3'd2;
  localparam logic [2:0] DOM_I2C = 3'd3;
  localparam logic [2:0] DOM_IMP = 3'd4;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GATE_W = 3'd1,
    STOP_W = 3'd2,
    LOAD   = 3'd3,
    RUN_W  = 3'd4,
    FIN    = 3'd5
  } state_e;
endpackage

// File: rtl/ma_settle_cnt.sv
// ma_settle_cnt: loadable down-counter that holds at zero and flags it
module ma_settle_cnt #(
  parameter int CW = 6
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic          en_i,
  input  logic [CW-1:0] val_i,
  output logic          zero_o
);
  logic [CW-1:0] cnt_q;
  assign zero_o = cnt_q == '0;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else if (load_i) cnt_q <= val_i;
    else if (en_i && !zero_o) cnt_q <= cnt_q - 1'b1;
  end
endmodule

// File: rtl/ma_clk_ctrl_seq.sv
// ma_clk_ctrl_seq: glitch-safe per-domain divider reconfiguration sequencer
module ma_clk_ctrl_seq
  import ma_clk_ctrl_pkg::*;
#(
  parameter int DIV_DW   = 4,
  parameter int N_DOM    = N_DOM_DEF,
  parameter int WAIT_CYC = 32,
  parameter int RST_DIV  = 1
) (
  input  logic                    src_clk,
  input  logic                    src_rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [2:0]              req_dom,
  input  logic [DIV_DW-1:0]       req_div,
  input  logic                    req_tog,
  input  logic                    req_cken,
  input  logic                    req_icg,
  output logic                    busy,
  output logic                    done_pulse,
  output logic [2:0]              done_dom,
  output logic                    err_pulse,
  output logic [N_DOM*DIV_DW-1:0] reg_clk_div,
  output logic [N_DOM-1:0]        reg_clk_tog,
  output logic [N_DOM-1:0]        reg_clk_cken,
  output logic [N_DOM-1:0]        reg_icg_on
);
  localparam int CW = $clog2(WAIT_CYC) + 1;
  localparam logic [CW-1:0] LOAD_V = CW'(WAIT_CYC - 1);
  localparam logic [DIV_DW-1:0] RST_V = DIV_DW'(RST_DIV);
  localparam logic [3:0] N_DOM_V = 4'(N_DOM);
  state_e state_q, state_d;
  logic [2:0] dom_q, dom_d, done_dom_q, done_dom_d;
  logic [DIV_DW-1:0] div_q, div_d;
  logic tog_q, tog_d, cken_q, cken_d, icg_q, icg_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [N_DOM*DIV_DW-1:0] clk_div_q, clk_div_d;
  logic [N_DOM-1:0] clk_tog_q, clk_tog_d, clk_cken_q, clk_cken_d, icg_on_q, icg_on_d;
  logic accept, illegal, fast, cnt_load, cnt_zero;
  assign req_ready = (state_q == IDLE) && !done_q;
  assign accept = req_valid && req_ready;
  assign illegal = {1'b0, req_dom} >= N_DOM_V;
  // Same ratio on a running divider: only the ICG needs touching
  assign fast = req_div == clk_div_q[req_dom*DIV_DW +: DIV_DW] && req_tog == clk_tog_q[req_dom]
             && clk_cken_q[req_dom] && req_cken;
  always_comb begin
    state_d = state_q;
    dom_d = dom_q;
    div_d = div_q;
    tog_d = tog_q;
    cken_d = cken_q;
    icg_d = icg_q;
    busy_d = busy_q;
    done_d = 1'b0;
    err_d = 1'b0;
    done_dom_d = done_dom_q;
    clk_div_d = clk_div_q;
    clk_tog_d = clk_tog_q;
    clk_cken_d = clk_cken_q;
    icg_on_d = icg_on_q;
    cnt_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (done_q) busy_d = 1'b0;
        if (accept && illegal) begin
          err_d = 1'b1;
          done_dom_d = req_dom;
        end else if (accept) begin
          dom_d = req_dom;
          div_d = req_div;
          tog_d = req_tog;
          cken_d = req_cken;
          icg_d = req_icg;
          busy_d = 1'b1;
          icg_on_d[req_dom] = fast ? req_icg : 1'b0;
          done_d = fast;
          done_dom_d = fast ? req_dom : done_dom_q;
          state_d = fast ? IDLE : GATE_W;
          cnt_load = !fast;
        end
      end
      GATE_W: if (cnt_zero) begin
        clk_cken_d[dom_q] = 1'b0;
        state_d = STOP_W;
        cnt_load = 1'b1;
      end
      STOP_W: if (cnt_zero) begin
        clk_div_d[dom_q*DIV_DW +: DIV_DW] = div_q;
        clk_tog_d[dom_q] = tog_q;
        state_d = LOAD;
      end
      LOAD: begin
        clk_cken_d[dom_q] = cken_q;
        state_d = cken_q ? RUN_W : FIN;
        cnt_load = cken_q;
      end
      RUN_W, FIN: if (cnt_zero || state_q == FIN) begin
        icg_on_d[dom_q] = icg_q;
        done_d = 1'b1;
        done_dom_d = dom_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge src_clk or negedge src_rst_n) begin
    if (!src_rst_n) begin
      state_q <= IDLE;
      dom_q <= '0;
      div_q <= '0;
      tog_q <= 1'b0;
      cken_q <= 1'b0;
      icg_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      done_dom_q <= '0;
      clk_div_q <= {N_DOM{RST_V}};
      clk_tog_q <= '0;
      clk_cken_q <= '1;
      icg_on_q <= '1;
    end else begin
      state_q <= state_d;
      dom_q <= dom_d;
      div_q <= div_d;
      tog_q <= tog_d;
      cken_q <= cken_d;
      icg_q <= icg_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      done_dom_q <= done_dom_d;
      clk_div_q <= clk_div_d;
      clk_tog_q <= clk_tog_d;
      clk_cken_q <= clk_cken_d;
      icg_on_q <= icg_on_d;
    end
  end
  ma_settle_cnt #(.CW(CW)) u_cnt (
    .clk_i  (src_clk),
    .rst_ni (src_rst_n),
    .load_i (cnt_load),
    .en_i   (state_q == GATE_W || state_q == STOP_W || state_q == RUN_W),
    .val_i  (LOAD_V),
    .zero_o (cnt_zero)
  );
  assign busy = busy_q;
  assign done_pulse = done_q;
  assign done_dom = done_dom_q;
  assign err_pulse = err_q;
  assign reg_clk_div = clk_div_q;
  assign reg_clk_tog = clk_tog_q;
  assign reg_clk_cken = clk_cken_q;
  assign reg_icg_on = icg_on_q;
endmodule

// File: tb/tb_ma_clk_ctrl_seq.sv
// tb_ma_clk_ctrl_seq: directed checks of the reconfiguration sequencer with WAIT_CYC=8
module tb_ma_clk_ctrl_seq;
  logic src_clk = 1'b0, src_rst_n = 1'b0;
  logic req_valid = 1'b0, req_ready;
  logic [2:0] req_dom = '0, done_dom;
  logic [3:0] req_div = '0;
  logic req_tog = 1'b0, req_cken = 1'b0, req_icg = 1'b0;
  logic busy, done_pulse, err_pulse;
  logic [19:0] reg_clk_div;
  logic [4:0] reg_clk_tog, reg_clk_cken, reg_icg_on;
  int tests = 0, fails = 0;
  logic seen_done;
  always #5 src_clk = ~src_clk;
  ma_clk_ctrl_seq #(.DIV_DW(4), .N_DOM(5), .WAIT_CYC(8), .RST_DIV(1)) dut (
    .src_clk(src_clk), .src_rst_n(src_rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_dom(req_dom), .req_div(req_div), .req_tog(req_tog), .req_cken(req_cken), .req_icg(req_icg),
    .busy(busy), .done_pulse(done_pulse), .done_dom(done_dom), .err_pulse(err_pulse),
    .reg_clk_div(reg_clk_div), .reg_clk_tog(reg_clk_tog), .reg_clk_cken(reg_clk_cken),
    .reg_icg_on(reg_icg_on)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge src_clk);
    #1;
  endtask
  task automatic issue(input logic [2:0] d, input logic [3:0] dv, input logic t, input logic c, input logic i);
    req_dom = d; req_div = dv; req_tog = t; req_cken = c; req_icg = i; req_valid = 1'b1;
    cyc(1);
    req_valid = 1'b0; req_div = 4'hF; req_tog = ~t; req_cken = ~c; req_icg = ~i;
  endtask
  initial begin
    cyc(2);
    src_rst_n = 1'b1;
    cyc(2);
    chk("rst_div", reg_clk_div, 20'h11111);
    chk("rst_cken", reg_clk_cken, 5'b11111);
    chk("rst_icg", reg_icg_on, 5'b11111);
    chk("rst_tog", reg_clk_tog, 5'b00000);
    chk("rst_ready_busy_done", {req_ready, busy, done_pulse, err_pulse, done_dom}, {4'b1000, 3'd0});
    // full path, dom 2, cken=1
    issue(3'd2, 4'd5, 1'b0, 1'b1, 1'b1);
    chk("f2_a1_icg", reg_icg_on, 5'b11011);
    chk("f2_a1_busy_ready", {busy, req_ready}, 2'b10);
    cyc(7);
    chk("f2_a8_cken", reg_clk_cken, 5'b11111);
    cyc(1);
    chk("f2_a9_cken", reg_clk_cken, 5'b11011);
    cyc(7);
    chk("f2_a16_div", reg_clk_div, 20'h11111);
    cyc(1);
    chk("f2_a17_div", reg_clk_div, 20'h11511);
    chk("f2_a17_cken", reg_clk_cken, 5'b11011);
    cyc(1);
    chk("f2_a18_cken", reg_clk_cken, 5'b11111);
    cyc(7);
    chk("f2_a25_icg_done", {reg_icg_on, done_pulse}, {5'b11011, 1'b0});
    cyc(1);
    chk("f2_a26_icg_done", {reg_icg_on, done_pulse, done_dom}, {5'b11111, 1'b1, 3'd2});
    chk("f2_a26_busy_ready", {busy, req_ready}, 2'b10);
    cyc(1);
    chk("f2_a27_idle", {done_pulse, busy, req_ready}, 3'b001);
    // fast path, dom 3
    issue(3'd3, 4'd1, 1'b0, 1'b1, 1'b0);
    chk("fp_a1_icg", reg_icg_on, 5'b10111);
    chk("fp_a1_done", {done_pulse, done_dom, busy, req_ready}, {1'b1, 3'd3, 2'b10});
    chk("fp_a1_cken", reg_clk_cken, 5'b11111);
    cyc(1);
    chk("fp_a2_idle", {done_pulse, busy, req_ready, reg_clk_cken}, {3'b001, 5'b11111});
    // illegal domain
    issue(3'd6, 4'd9, 1'b1, 1'b0, 1'b0);
    chk("il_a1_err", {err_pulse, done_pulse, done_dom, busy}, {2'b10, 3'd6, 1'b0});
    chk("il_a1_regs", {reg_clk_div, reg_clk_tog, reg_clk_cken, reg_icg_on}, {20'h11511, 5'b00000, 5'b11111, 5'b10111});
    cyc(1);
    chk("il_a2_err", {err_pulse, req_ready}, 2'b01);
    // full path, dom 1, cken=0
    issue(3'd1, 4'd3, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 19; k++) begin
      chk("c0_others", {reg_clk_div & 20'hFFF0F, reg_clk_tog & 5'b11101, reg_clk_cken & 5'b11101, reg_icg_on & 5'b11101},
          {20'h11501, 5'b00000, 5'b11101, 5'b10101});
      if (k == 8) chk("c0_a8_cken", reg_clk_cken, 5'b11111);
      if (k == 10) chk("c0_a10_cken", reg_clk_cken, 5'b11101);
      if (k == 18) chk("c0_a18_done", {done_pulse, reg_clk_div}, {1'b0, 20'h11531});
      if (k < 19) cyc(1);
    end
    chk("c0_a19_done", {done_pulse, done_dom}, {1'b1, 3'd1});
    chk("c0_a19_regs", {reg_clk_div, reg_clk_tog, reg_clk_cken, reg_icg_on}, {20'h11531, 5'b00010, 5'b11101, 5'b10101});
    cyc(1);
    // reset mid-sequence, dom 0
    issue(3'd0, 4'd7, 1'b0, 1'b1, 1'b1);
    cyc(11);
    chk("mr_a12_pre", {reg_clk_cken, reg_icg_on, busy}, {5'b11100, 5'b10100, 1'b1});
    src_rst_n = 1'b0;
    #1;
    chk("mr_async", {reg_clk_div, reg_clk_tog, reg_clk_cken, reg_icg_on, busy, done_pulse, done_dom},
        {20'h11111, 5'b00000, 5'b11111, 5'b11111, 2'b00, 3'd0});
    cyc(2);
    src_rst_n = 1'b1;
    cyc(1);
    chk("mr_ready", req_ready, 1'b1);
    seen_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      seen_done = seen_done | done_pulse;
      cyc(1);
    end
    chk("mr_no_done", {seen_done, reg_clk_div, busy}, {1'b0, 20'h11111, 1'b0});
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ma_clk_ctrl_seq.md
Name: ma_clk_ctrl_seq

Overview:
- Upstream control stage for the clock-group generator. Owns the per-domain divider, toggle, clock-enable and ICG-enable register outputs that the generator consumes.
- Applies software reconfiguration requests glitch-safely, one domain at a time, with the sequence: gate ICG, stop divider, load new ratio, restart, ungate.
- Domain index order: 0=CPU, 1=AXI, 2=APB, 3=I2C, 4=IMP.

Parameters:
- DIV_DW, 4, divider ratio width; must match the generator's DIV_DW.
- N_DOM, 5, number of clock domains.
- WAIT_CYC, 32, src_clk cycles per settle phase; must be ≥ 2×(slowest divided period) in src_clk cycles.
- RST_DIV, 1, reset divider value for every domain.

Ports:
- src_clk  in  1  source clock.
- src_rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  reconfiguration request valid.
- req_ready  out  1  request accepted when valid&ready.
- req_dom  in  3  target domain index.
- req_div  in  DIV_DW  new divider ratio.
- req_tog  in  1  new toggle setting.
- req_cken  in  1  final clock-enable state.
- req_icg  in  1  final ICG-enable state.
- busy  out  1  sequence in progress.
- done_pulse  out  1  one-cycle completion strobe.
- done_dom  out  3  domain of the last completed or rejected request.
- err_pulse  out  1  one-cycle strobe for an illegal req_dom.
- reg_clk_div  out  N_DOM×DIV_DW  packed divider ratios; domain d occupies [d×DIV_DW +: DIV_DW].
- reg_clk_tog  out  N_DOM  per-domain toggle.
- reg_clk_cken  out  N_DOM  per-domain divider enable.
- reg_icg_on  out  N_DOM  per-domain ICG enable.

Behaviour:
- Single clock src_clk; asynchronous active-low reset src_rst_n. All outputs registered.
- Reset values:
  - reg_clk_div = RST_DIV in every slot; reg_clk_tog = 0; reg_clk_cken = all 1; reg_icg_on = all 1.
  - busy, done_pulse, err_pulse = 0; done_dom = 0; FSM = IDLE; settle counter = 0.
- req_ready = (state==IDLE) && !done_pulse, so there is one idle cycle between back-to-back requests. Request fields are captured on acceptance; later input changes are ignored.
- FSM states: IDLE, GATE_W, STOP_W, LOAD, RUN_W, FIN.
- Timing below is counted in edges after the accepting edge A, with W=WAIT_CYC:
  - Illegal domain (req_dom ≥ N_DOM): at A+1, err_pulse=1 and done_dom=req_dom. No register changes, no done_pulse. Stay in IDLE.
  - Fast path (req_div and req_tog equal the current values, and reg_clk_cken[d]=1 and req_cken=1): at A+1, reg_icg_on[d]=req_icg and done_pulse=1. No stop phase.
  - Full path:
    - A+1: reg_icg_on[d]=0; enter GATE_W; counter=W−1.
    - A+1+W: reg_clk_cken[d]=0; enter STOP_W.
    - A+1+2W: div/tog slot d loaded; enter LOAD.
    - A+2+2W: reg_clk_cken[d]=req_cken; enter RUN_W if req_cken=1, else FIN.
    - A+2+3W (cken=1 case): reg_icg_on[d]=req_icg, done_pulse=1, return to IDLE.
    - cken=0 case: FIN completes at A+3+2W with reg_icg_on[d]=req_icg and done_pulse=1.
- busy = 1 from A+1 until the done_pulse edge inclusive.
- Only slot d changes during a sequence; other domains are untouched at every cycle.
- Counter: decrements to 0; leaves the wait state on the edge where the count is 0. WAIT_CYC=1 is legal.
- Reset asserted mid-sequence forces reset values immediately (asynchronously). The in-flight request is dropped and no done_pulse is emitted.
- req_valid held while busy is ignored until ready.

Decomposition:
- Package ma_clk_ctrl_pkg: FSM state enum; domain index constants DOM_CPU..DOM_IMP; N_DOM_DEF=5.
- One sub-module, ma_settle_cnt: loadable down-counter with a zero flag, width $clog2(WAIT_CYC)+1.

Test Plan:
- Reset release with no requests → reg_clk_div=0x11111 (DIV_DW=4, RST_DIV=1), cken=5'b11111, icg=5'b11111, req_ready=1.
- W=8: request dom=2, div=5, tog=0, cken=1, icg=1 accepted at A → icg[2] low at A+1, cken[2] low at A+9, div slot 2=5 at A+17, cken[2] high at A+18, icg[2] high with done_pulse at A+26, done_dom=2.
- Request dom=3 with div/tog unchanged, icg=0 → icg[3]=0 and done_pulse at A+1; cken[3] never drops.
- Request dom=6 → err_pulse at A+1, done_dom=6, all outputs unchanged, no done_pulse.
- Request dom=1 with cken=0, icg=0 → done at A+19; final cken[1]=0 and icg[1]=0; the other four domains stay constant throughout.
- Assert src_rst_n low at A+12 of a dom=0 sequence → all outputs return to reset values asynchronously; after release req_ready=1 and no done_pulse appears.
